// File: rtl/ring_dec_pkg.sv
// Shared types and constants for the ring-counter sequence decoder.
package ring_dec_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned ERRCNT_W = 8;
  // Wide enough for the largest legal lock threshold (15).
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary conversion with a strict one-hot flag
// (all-zero and multi-bit inputs are reported as not one-hot).
module onehot_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] bin_c,
  output logic                     is_onehot_c
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic seen;
  logic multi;

  // OR of set-bit positions is the exact index whenever only one bit is set.
  always_comb begin
    bin_c = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        bin_c = bin_c | IDX_W'(i);
      end
    end
    is_onehot_c = seen & ~multi;
  end

endmodule

// File: rtl/ring_seq_decoder.sv
// Tracks a rotating one-hot ring counter: decodes its position, detects lock
// and sequence errors. Optional error counter enabled by RING_DEC_ERRCNT_EN.
module ring_seq_decoder
  import ring_dec_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     seq_err,
  output logic [ERRCNT_W-1:0]      err_count
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_t             state, state_n;
  logic [WIDTH-1:0]   stored, stored_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [IDX_W-1:0]   index_n;
  logic               idx_valid_n;
  logic               locked_n;
  logic               seq_err_n;

  logic [IDX_W-1:0]   bin_c;
  logic               is_onehot_c;
  logic [WIDTH-1:0]   expected_c;
  logic               match_c;

  onehot_to_bin #(.WIDTH(WIDTH)) u_onehot_to_bin (
    .vec         (ring_in),
    .bin_c       (bin_c),
    .is_onehot_c (is_onehot_c)
  );

  assign expected_c = {stored[WIDTH-2:0], stored[WIDTH-1]};
  assign match_c    = (ring_in == expected_c);
  assign cnt_inc    = cnt + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      stored    <= '0;
      cnt       <= '0;
      index     <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_n;
      stored    <= stored_n;
      cnt       <= cnt_n;
      index     <= index_n;
      idx_valid <= idx_valid_n;
      locked    <= locked_n;
      seq_err   <= seq_err_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    stored_n    = stored;
    cnt_n       = cnt;
    index_n     = index;
    idx_valid_n = 1'b0;
    seq_err_n   = 1'b0;

    if (sample_valid) begin
      if (is_onehot_c) begin
        stored_n    = ring_in;
        index_n     = bin_c;
        idx_valid_n = 1'b1;
      end

      unique case (state)
        HUNT: begin
          if (is_onehot_c) begin
            state_n = ACQ;
            cnt_n   = '0;
          end
        end
        ACQ: begin
          if (match_c) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_W'(LOCK_CNT)) begin
              state_n = LOCKED;
            end
          end else if (is_onehot_c) begin
            seq_err_n = 1'b1;
            cnt_n     = '0;
          end else begin
            seq_err_n = 1'b1;
            state_n   = HUNT;
          end
        end
        LOCKED: begin
          if (!match_c) begin
            seq_err_n = 1'b1;
            state_n   = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    locked_n = (state_n == LOCKED);
  end

`ifdef RING_DEC_ERRCNT_EN
  // Saturating violation counter; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (seq_err_n && (err_count != {ERRCNT_W{1'b1}})) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_ring_seq_decoder.sv
// Scoreboard bench for ring_seq_decoder: directed scenarios plus random
// traffic against a position-based reference model.
module tb_ring_seq_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned LC = 3;
`ifdef RING_DEC_ERRCNT_EN
  localparam bit ECNT = 1'b1;
`else
  localparam bit ECNT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_valid;
  logic [W-1:0] ring_in;
  logic         err_clr;
  logic [1:0]   index;
  logic         idx_valid;
  logic         locked;
  logic         seq_err;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  ring_seq_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .ring_in      (ring_in),
    .err_clr      (err_clr),
    .index        (index),
    .idx_valid    (idx_valid),
    .locked       (locked),
    .seq_err      (seq_err),
    .err_count    (err_count)
  );

  typedef struct packed {
    logic       iv;
    logic [1:0] idx;
    logic       lk;
    logic       se;
    logic [7:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0=searching, 1=acquiring, 2=locked; positions are integers.
  int m_mode  = 0;
  int m_prev  = -1;
  int m_cnt   = 0;
  int m_index = 0;
  bit m_iv    = 0;
  bit m_se    = 0;
  int m_ec    = 0;

  function automatic int pos_of(input logic [W-1:0] d);
    for (int i = 0; i < int'(W); i++) if (d[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input logic r, input logic v, input logic [W-1:0] d, input logic c);
    bit oh, match;
    int p;
    if (r) begin
      m_mode = 0; m_prev = -1; m_cnt = 0; m_index = 0;
      m_iv = 0; m_se = 0; m_ec = 0;
      return;
    end
    m_iv = 0;
    m_se = 0;
    if (v) begin
      oh    = ($countones(d) == 1);
      p     = oh ? pos_of(d) : -1;
      match = oh && (m_prev >= 0) && (p == (m_prev + 1) % int'(W));
      case (m_mode)
        0: if (oh) begin m_mode = 1; m_cnt = 0; end
        1: begin
          if (match) begin
            m_cnt++;
            if (m_cnt == int'(LC)) m_mode = 2;
          end else begin
            m_se = 1;
            if (oh) m_cnt = 0;
            else    m_mode = 0;
          end
        end
        default: if (!match) begin m_se = 1; m_mode = 0; end
      endcase
      if (oh) begin m_iv = 1; m_index = p; m_prev = p; end
    end
    if (ECNT) begin
      if (c) m_ec = 0;
      else if (m_se && m_ec < 255) m_ec++;
    end
  endtask

  // Apply one cycle of stimulus, then push the model's prediction for it.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic c);
    exp_t e;
    reset = r; sample_valid = v; ring_in = d; err_clr = c;
    @(posedge clk);
    #1;
    model_update(r, v, d, c);
    e.iv  = m_iv;
    e.idx = 2'(m_index);
    e.lk  = (m_mode == 2);
    e.se  = m_se;
    e.ec  = 8'(m_ec);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare each predicted response on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("idx_valid", 32'(idx_valid), 32'(e.iv));
      cmp("index",     32'(index),     32'(e.idx));
      cmp("locked",    32'(locked),    32'(e.lk));
      cmp("seq_err",   32'(seq_err),   32'(e.se));
      cmp("err_count", 32'(err_count), 32'(e.ec));
    end
  end

  task automatic ring_pass();
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0100, 0);
    step(0, 1, 4'b1000, 0);
  endtask

  initial begin
    int t;
    int sel;
    logic [W-1:0] d;
    reset = 1'b1; sample_valid = 1'b0; ring_in = '0; err_clr = 1'b0;
    step(1, 0, 4'b0000, 0);
    step(1, 1, 4'b0001, 1);
    step(0, 0, 4'b0000, 0);

    // Acquire and lock, then wrap-around while locked.
    ring_pass();
    step(0, 0, 4'b0000, 0);
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b0100, 0);
    step(0, 1, 4'b1000, 0);
    step(0, 1, 4'b0001, 0);

    // Multi-bit sample while locked.
    step(0, 1, 4'b0011, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);

    // Relock, then skip a position while locked, then relock again.
    ring_pass();
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0010, 0);
    step(0, 1, 4'b1000, 0);
    ring_pass();

    // Reset while locked with a valid sample present.
    step(1, 1, 4'b0001, 0);
    step(0, 0, 4'b0000, 0);

    // Error counter saturation, then clear with a coincident violation.
    step(0, 1, 4'b0001, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0001, 1);
    step(0, 0, 4'b0000, 0);

    // Random traffic biased towards correct rotation.
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      d = W'(1) << ((m_prev < 0) ? 0 : (m_prev + 1) % int'(W));
      else if (sel < 85) d = W'(1) << $urandom_range(0, W - 1);
      else               d = W'($urandom_range(0, (1 << W) - 1));
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
           d,
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    step(0, 0, 4'b0000, 0);

    t = 0;
    while (exp_q.size() > 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
